// File: rtl/meter_pkg.sv
// -----------------------------------------------------------------------------
// meter_pkg
//
// Shared definitions for the meter peak-hold store:
//   - default sample and magnitude widths
//   - FSM state enum for the store controller
//   - RAM word layout: peak magnitude, plus a sticky clip bit when the
//     METER_CLIP_FLAG_EN macro is defined
//   - meter_mag(): signed sample to saturated magnitude conversion
//
// Configuration macro: METER_CLIP_FLAG_EN (adds the clip bit to each word).
// -----------------------------------------------------------------------------
package meter_pkg;

  localparam int MTR_IO_WIDTH  = 24;
  localparam int MTR_MAG_WIDTH = MTR_IO_WIDTH - 1;

  // CLEAR: post-reset zeroing sweep; IDLE: serving meter traffic;
  // CPU_RD: capturing read data; CPU_RSP: presenting the response pulse.
  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    IDLE    = 2'd1,
    CPU_RD  = 2'd2,
    CPU_RSP = 2'd3
  } meter_state_t;

`ifdef METER_CLIP_FLAG_EN
  typedef struct packed {
    logic                     clip;
    logic [MTR_MAG_WIDTH-1:0] peak;
  } meter_word_t;
`else
  typedef struct packed {
    logic [MTR_MAG_WIDTH-1:0] peak;
  } meter_word_t;
`endif

  // Absolute value of a two's-complement sample. The most negative code has
  // no positive counterpart in the narrower magnitude, so it saturates to
  // all ones instead of wrapping to zero.
  function automatic logic [MTR_MAG_WIDTH-1:0] meter_mag(
    input logic [MTR_IO_WIDTH-1:0] sample
  );
    logic [MTR_IO_WIDTH-1:0] negated;
    negated = -sample;
    if (!sample[MTR_IO_WIDTH-1]) begin
      return sample[MTR_MAG_WIDTH-1:0];
    end
    if (negated[MTR_IO_WIDTH-1]) begin
      return '1;
    end
    return negated[MTR_MAG_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/meter_ram.sv
// -----------------------------------------------------------------------------
// meter_ram
//
// Simple dual-port RAM with one write port and one registered read port,
// written so it maps onto an M10K block. A read and a write to the same
// address in the same cycle return the old contents; the store above
// forwards the fresh value itself.
//
// Parameters:
//   DATA_W  word width
//   ADDR_W  address width (2**ADDR_W words)
//
// Ports:
//   clk      clock
//   wr_en    write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address, sampled every cycle
//   rd_data  read data, one cycle after rd_addr
//
// Configuration macro: none.
// -----------------------------------------------------------------------------
module meter_ram #(
  parameter int DATA_W = 23,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Kept in its own process so a same-address write never shows through
  // on the read port in the same cycle.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/meter_peak_store.sv
// -----------------------------------------------------------------------------
// meter_peak_store
//
// Peak-hold store for the DSP meter write stream. Every meter write turns a
// signed sample into a saturated magnitude and folds it into a per-slot
// running maximum held in block RAM (read-modify-write, one update per
// cycle). The CPU polls slots through a request/valid read port, optionally
// zeroing the slot as it reads. After reset the whole RAM is swept to zero
// before `ready` rises.
//
// Parameters:
//   IO_WIDTH          signed sample width (magnitude is IO_WIDTH-1 bits);
//                     must match meter_pkg::MTR_IO_WIDTH
//   METER_ADDR_WIDTH  slot address width
//   CLIP_LEVEL        magnitude at or above which the clip bit sets
//
// Ports:
//   clk            clock, single domain
//   reset_n        synchronous active-low reset
//   meter_wr_data  signed meter sample
//   meter_wr_addr  meter slot
//   meter_wr_en    meter write strobe (no backpressure)
//   cpu_rd_req     CPU read request, held until cpu_rd_valid
//   cpu_rd_addr    slot to read
//   cpu_rd_clear   zero the slot once it has been read
//   cpu_rd_valid   one-cycle response pulse
//   cpu_rd_data    peak magnitude of the slot
//   cpu_rd_clip    sticky clip flag of the slot
//   ready          high once the post-reset sweep has finished
//
// Configuration macro: METER_CLIP_FLAG_EN adds a sticky clip bit to each
// RAM word; without it cpu_rd_clip is tied low.
// -----------------------------------------------------------------------------
module meter_peak_store
  import meter_pkg::*;
#(
  parameter int                  IO_WIDTH         = MTR_IO_WIDTH,
  parameter int                  METER_ADDR_WIDTH = 8,
  parameter logic [IO_WIDTH-1:0] CLIP_LEVEL       = 24'h7FFF00
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [IO_WIDTH-1:0]         meter_wr_data,
  input  logic [METER_ADDR_WIDTH-1:0] meter_wr_addr,
  input  logic                        meter_wr_en,
  input  logic                        cpu_rd_req,
  input  logic [METER_ADDR_WIDTH-1:0] cpu_rd_addr,
  input  logic                        cpu_rd_clear,
  output logic                        cpu_rd_valid,
  output logic [IO_WIDTH-2:0]         cpu_rd_data,
  output logic                        cpu_rd_clip,
  output logic                        ready
);

  localparam int WORD_W = $bits(meter_word_t);

  meter_state_t                state;
  logic [METER_ADDR_WIDTH-1:0] sweep_cnt;
  logic [METER_ADDR_WIDTH-1:0] cpu_addr_q;
  logic                        cpu_clear_q;

  logic                        s0_fire;
  logic                        cpu_accept;
  logic [MTR_MAG_WIDTH-1:0]    mag_now;

  logic                        s1_valid;
  logic [METER_ADDR_WIDTH-1:0] s1_addr;
  logic [MTR_MAG_WIDTH-1:0]    s1_mag;
`ifdef METER_CLIP_FLAG_EN
  logic                        s1_clip;
`endif

  logic [METER_ADDR_WIDTH-1:0] rd_addr;
  logic [METER_ADDR_WIDTH-1:0] rd_addr_q;
  meter_word_t                 ram_rd;
  meter_word_t                 rd_word;
  meter_word_t                 new_word;

  logic                        wr_en;
  logic [METER_ADDR_WIDTH-1:0] wr_addr;
  meter_word_t                 wr_data;

  logic                        wr_q_en;
  logic [METER_ADDR_WIDTH-1:0] wr_q_addr;
  meter_word_t                 wr_q_data;

  // Meter updates run in every state except the sweep. A CPU read can only
  // be taken in IDLE on a cycle with no meter strobe, which keeps the
  // single RAM read port free for it and gives meter traffic priority.
  assign s0_fire    = meter_wr_en && (state != CLEAR);
  assign cpu_accept = (state == IDLE) && cpu_rd_req && !meter_wr_en;
  assign mag_now    = meter_mag(meter_wr_data);

  // The read port is shared: meter slot when a strobe is present, CPU slot
  // otherwise. The two uses never fall in the same cycle.
  assign rd_addr = meter_wr_en ? meter_wr_addr : cpu_rd_addr;

  meter_ram #(
    .DATA_W (WORD_W),
    .ADDR_W (METER_ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (ram_rd)
  );

  // The RAM hands back pre-write contents when the read and a write hit the
  // same slot in one cycle. The write of that cycle is remembered in wr_q_*
  // and substituted here, so both a chained meter update and a CPU read see
  // the value that was just committed (including a clear-on-read zero).
  always_comb begin
    rd_word = ram_rd;
    if (wr_q_en && (wr_q_addr == rd_addr_q)) begin
      rd_word = wr_q_data;
    end
  end

  // Stage-1 merge: the stored peak only ever grows, and the clip bit is
  // sticky until a clear.
  always_comb begin
    new_word = rd_word;
    if (s1_mag > rd_word.peak) begin
      new_word.peak = s1_mag;
    end
`ifdef METER_CLIP_FLAG_EN
    new_word.clip = rd_word.clip | s1_clip;
`endif
  end

  // Single RAM write port. The sweep owns it during CLEAR. Afterwards the
  // clear-on-read (CPU_RD) and stage-1 write-back cannot coincide, since an
  // accepted read implies no meter strobe in the cycle before CPU_RD. Writes
  // other than the sweep are suppressed while reset is asserted so an
  // in-flight update is discarded rather than committed.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sweep_cnt;
    wr_data = '0;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = sweep_cnt;
    end else if ((state == CPU_RD) && cpu_clear_q) begin
      wr_en   = reset_n;
      wr_addr = cpu_addr_q;
    end else if (s1_valid) begin
      wr_en   = reset_n;
      wr_addr = s1_addr;
      wr_data = new_word;
    end
  end

  // Stage-0 registers for the meter pipeline, plus the one-cycle history of
  // the read address and the RAM write used by the forwarding mux.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_mag    <= '0;
`ifdef METER_CLIP_FLAG_EN
      s1_clip   <= 1'b0;
`endif
      rd_addr_q <= '0;
      wr_q_en   <= 1'b0;
      wr_q_addr <= '0;
      wr_q_data <= '0;
    end else begin
      s1_valid  <= s0_fire;
      s1_addr   <= meter_wr_addr;
      s1_mag    <= mag_now;
`ifdef METER_CLIP_FLAG_EN
      s1_clip   <= ({1'b0, mag_now} >= CLIP_LEVEL);
`endif
      rd_addr_q <= rd_addr;
      wr_q_en   <= wr_en;
      wr_q_addr <= wr_addr;
      wr_q_data <= wr_data;
    end
  end

  // Controller: zeroing sweep after reset, then the CPU read handshake.
  // A response is captured in CPU_RD from the forwarded read of the accept
  // cycle and presented as a one-cycle pulse in CPU_RSP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= CLEAR;
      sweep_cnt    <= '0;
      ready        <= 1'b0;
      cpu_addr_q   <= '0;
      cpu_clear_q  <= 1'b0;
      cpu_rd_valid <= 1'b0;
      cpu_rd_data  <= '0;
`ifdef METER_CLIP_FLAG_EN
      cpu_rd_clip  <= 1'b0;
`endif
    end else begin
      case (state)
        CLEAR: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == '1) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          if (cpu_accept) begin
            state       <= CPU_RD;
            cpu_addr_q  <= cpu_rd_addr;
            cpu_clear_q <= cpu_rd_clear;
          end
        end
        CPU_RD: begin
          cpu_rd_data  <= rd_word.peak;
`ifdef METER_CLIP_FLAG_EN
          cpu_rd_clip  <= rd_word.clip;
`endif
          cpu_rd_valid <= 1'b1;
          state        <= CPU_RSP;
        end
        CPU_RSP: begin
          cpu_rd_valid <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

`ifndef METER_CLIP_FLAG_EN
  assign cpu_rd_clip = 1'b0;
`endif

endmodule

// File: tb/tb_meter_peak_store.sv
// -----------------------------------------------------------------------------
// tb_meter_peak_store
//
// Self-checking bench for meter_peak_store. The reference is an array of
// per-slot peaks updated as each meter write is issued; a CPU read snapshots
// the array at accept time and applies its clear. Expected responses go into
// a queue; a monitor pops and compares whenever cpu_rd_valid is seen.
// Honours METER_CLIP_FLAG_EN for the expected clip flag.
// -----------------------------------------------------------------------------
module tb_meter_peak_store;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] meter_wr_data = '0;
  logic [7:0]  meter_wr_addr = '0;
  logic        meter_wr_en = 1'b0;
  logic        cpu_rd_req = 1'b0;
  logic [7:0]  cpu_rd_addr = '0;
  logic        cpu_rd_clear = 1'b0;
  logic        cpu_rd_valid;
  logic [22:0] cpu_rd_data;
  logic        cpu_rd_clip;
  logic        ready;

  meter_peak_store dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .meter_wr_data (meter_wr_data),
    .meter_wr_addr (meter_wr_addr),
    .meter_wr_en   (meter_wr_en),
    .cpu_rd_req    (cpu_rd_req),
    .cpu_rd_addr   (cpu_rd_addr),
    .cpu_rd_clear  (cpu_rd_clear),
    .cpu_rd_valid  (cpu_rd_valid),
    .cpu_rd_data   (cpu_rd_data),
    .cpu_rd_clip   (cpu_rd_clip),
    .ready         (ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [22:0] data;
    logic        clip;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [22:0] model_peak [256];
  logic        model_clip [256];
  int          next_ok = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int refMag(input logic [23:0] d);
    int v;
    v = $signed(d);
    if (v < 0) v = -v;
    if (v > 'h7FFFFF) v = 'h7FFFFF;
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 256; i++) begin
      model_peak[i] = '0;
      model_clip[i] = 1'b0;
    end
    next_ok = 0;
  endtask

  // Drives one cycle of inputs, lets the edge sample them, then updates the
  // reference. A read is taken when no meter strobe is present and the
  // previous read is at least three edges old.
  task automatic applyStimulus(input logic wen, input logic [7:0] waddr, input logic [23:0] wdata,
                               input logic rreq, input logic [7:0] raddr, input logic rclr,
                               output logic acc);
    int   now;
    int   m;
    exp_t e;
    meter_wr_en   = wen;
    meter_wr_addr = waddr;
    meter_wr_data = wdata;
    cpu_rd_req    = rreq;
    cpu_rd_addr   = raddr;
    cpu_rd_clear  = rclr;
    @(posedge clk);
    #1;
    now = cyc;
    acc = 1'b0;
    if (wen) begin
      m = refMag(wdata);
      if (m > int'(model_peak[waddr])) model_peak[waddr] = m[22:0];
      if (m >= 'h7FFF00) model_clip[waddr] = 1'b1;
    end else if (rreq && now >= next_ok) begin
      acc    = 1'b1;
      e.data = model_peak[raddr];
`ifdef METER_CLIP_FLAG_EN
      e.clip = model_clip[raddr];
`else
      e.clip = 1'b0;
`endif
      e.cyc  = now + 1;
      sb.push_back(e);
      if (rclr) begin
        model_peak[raddr] = '0;
        model_clip[raddr] = 1'b0;
      end
      next_ok = now + 3;
    end
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [23:0] d);
    logic acc;
    applyStimulus(1'b1, a, d, 1'b0, 8'd0, 1'b0, acc);
  endtask

  task automatic doRead(input logic [7:0] a, input logic clr);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) applyStimulus(1'b0, 8'd0, 24'd0, 1'b1, a, clr, acc);
  endtask

  task automatic idleCycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0, acc);
  endtask

  task automatic checkResetOutputs(input string tag);
    @(negedge clk);
    checkOutput({tag, "_ready"}, ready, 0);
    checkOutput({tag, "_valid"}, cpu_rd_valid, 0);
    checkOutput({tag, "_data"}, cpu_rd_data, 0);
    checkOutput({tag, "_clip"}, cpu_rd_clip, 0);
  endtask

  // Counts edges after reset release until ready is first seen high.
  task automatic waitReady(input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        n = i;
        break;
      end
    end
    checkOutput(tag, n, 256);
  endtask

  // Monitor: every response pulse must match the oldest outstanding read.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (cpu_rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got cpu_rd_valid at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("rd_data", cpu_rd_data, e.data);
        checkOutput("rd_clip", cpu_rd_clip, e.clip);
        checkOutput("rd_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic        acc;
    logic        pend;
    logic [7:0]  paddr;
    logic        pclr;
    logic [23:0] d;

    modelReset();
    repeat (3) @(posedge clk);
    checkResetOutputs("reset");
    reset_n = 1'b1;
    waitReady("ready_latency");

    doRead(8'd0, 1'b0);
    doRead(8'd200, 1'b0);

    // Mixed-sign writes to slot 5, then a strictly rising chain on slot 7.
    doWrite(8'd5, 24'h000100);
    doWrite(8'd5, 24'hFFFF00);
    doWrite(8'd5, 24'h000080);
    doRead(8'd5, 1'b0);
    doWrite(8'd7, 24'h000001);
    doWrite(8'd7, 24'h000002);
    doWrite(8'd7, 24'h000003);
    doWrite(8'd7, 24'h000010);
    doRead(8'd7, 1'b0);

    // Most negative code saturates; clear-on-read zeroes the slot.
    doWrite(8'd9, 24'h800000);
    doRead(8'd9, 1'b1);
    doRead(8'd9, 1'b0);

    // Meter write landing in CPU_RD of a clearing read of the same slot.
    doWrite(8'd3, 24'h000200);
    doRead(8'd3, 1'b1);
    doWrite(8'd3, 24'h000400);
    doRead(8'd3, 1'b0);

    // Request held through 20 cycles of meter traffic.
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 8'($urandom_range(30, 40)), 24'($urandom), 1'b1, 8'd20, 1'b0, acc);
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b1, 8'd20, 1'b0, acc);

    // Clip flag: set near full scale, sticky, dropped by clear-on-read.
    doWrite(8'd1, 24'h7FFFF0);
    doWrite(8'd1, 24'h000010);
    doRead(8'd1, 1'b0);
    doRead(8'd1, 1'b1);
    doRead(8'd1, 1'b0);

    // Random traffic over a few slots to stress forwarding and collisions.
    pend = 1'b0;
    paddr = '0;
    pclr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 5))
        0:       d = 24'h800000;
        1:       d = 24'h7FFF00 + 24'($urandom_range(0, 255));
        2:       d = 24'h800000 + 24'($urandom_range(1, 512));
        default: d = 24'($urandom);
      endcase
      if (!pend && $urandom_range(0, 7) == 0) begin
        pend  = 1'b1;
        paddr = 8'($urandom_range(0, 7));
        pclr  = 1'($urandom_range(0, 1));
      end
      applyStimulus(1'($urandom_range(0, 99) < 60), 8'($urandom_range(0, 7)), d,
                    pend, paddr, pclr, acc);
      if (acc) pend = 1'b0;
    end
    idleCycles(6);
    checkOutput("scoreboard_drain", sb.size(), 0);

    // Reset with a read accepted and a meter update in flight: no response,
    // sweep restarts, and requests/strobes are ignored during the sweep.
    doWrite(8'd5, 24'h001234);
    doRead(8'd5, 1'b0);
    void'(sb.pop_back());
    reset_n       = 1'b0;
    meter_wr_en   = 1'b1;
    meter_wr_addr = 8'd6;
    meter_wr_data = 24'h054321;
    cpu_rd_req    = 1'b1;
    cpu_rd_addr   = 8'd5;
    cpu_rd_clear  = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    checkResetOutputs("midreset");
    reset_n = 1'b1;
    waitReady("ready_latency_again");
    doRead(8'd5, 1'b0);
    doRead(8'd6, 1'b0);
    idleCycles(6);
    checkOutput("scoreboard_drain_final", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
